// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch channel: request/address out, word/ready back.
// The master modport is the fetch unit; the slave modport is the instruction memory.
interface instr_fetch_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding the control decoder: PC, ready-handshake fetch, instruction register.
// Define FETCH_TIMEOUT_EN to add a FETCH watchdog that faults after TIMEOUT_CYCLES wait cycles.
module instr_fetch_unit #(
  parameter int unsigned     XLEN           = 64,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter logic [31:0]     NOP_INSTR      = 32'h0000_0013,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   imem,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
`ifdef FETCH_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        // A ready arriving on the limit cycle still captures; only a silent limit cycle faults.
        else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end
      S_ISSUE: begin
        if (!stall) begin
          valid_d = 1'b0;
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = branch_taken ? branch_target : pc_q + XLEN'(4);
            state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end
        end
      end
      S_HALT: valid_d = 1'b0;
      default: state_d = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
`ifdef FETCH_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign instr_valid    = valid_q;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then randomized traffic,
// all compared against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

  localparam int unsigned XLEN    = 64;
  localparam logic [63:0] RST_PC  = 64'h0;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0;
  logic            branch_taken = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic            instr_valid;
  logic            fetch_fault;

  instr_fetch_if #(.XLEN(XLEN)) imem_if ();

  instr_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RST_PC), .NOP_INSTR(NOP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .imem(imem_if.master),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the stage is holding, described in terms of fetch transactions.
  bit          m_booting;   // one dead cycle owed after reset release
  bit          m_halted;    // stopped for good until reset
  bit          m_holding;   // an instruction is being presented downstream
  bit          m_fault;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  int          m_waits;     // wait-state cycles spent on the current fetch

  function automatic void model_reset();
    m_booting = 1; m_halted = 0; m_holding = 0; m_fault = 0;
    m_pc = RST_PC; m_instr = NOP; m_waits = 0;
  endfunction

  function automatic void model_advance(input bit rdy, input logic [31:0] rd, input bit st,
                                        input bit bt, input logic [63:0] tgt);
    if (m_halted) return;
    if (m_booting) begin
      m_booting = 0;
      m_waits = 0;
    end else if (!m_holding) begin
      if (rdy) begin
        m_holding = 1;
        m_instr = rd;
      end else begin
        m_waits++;
`ifdef FETCH_TIMEOUT_EN
        if (m_waits >= TIMEOUT) begin m_fault = 1; m_halted = 1; end
`endif
      end
    end else if (!st) begin
      m_holding = 0;
      m_waits = 0;
      if (bt && (tgt % 4 != 0)) begin
        m_fault = 1;
        m_halted = 1;
      end else begin
        m_pc = bt ? tgt : m_pc + 64'd4;
      end
    end
  endfunction

  task automatic compare_all();
    check("imem_req",    imem_if.imem_req, !m_booting && !m_halted && !m_holding);
    check("imem_addr",   imem_if.imem_addr, m_pc);
    check("pc",          pc, m_pc);
    check("instr",       instr, m_instr);
    check("opcode",      opcode, m_instr[6:0]);
    check("instr_valid", instr_valid, m_holding);
    check("fetch_fault", fetch_fault, m_fault);
  endtask

  // One clock: drive inputs, check current outputs against the model, advance both.
  task automatic step(input bit rdy, input logic [31:0] rd, input bit st,
                      input bit bt, input logic [63:0] tgt);
    imem_if.imem_ready = rdy;
    imem_if.imem_rdata = rd;
    stall = st;
    branch_taken = bt;
    branch_target = tgt;
    compare_all();
    model_advance(rdy, rd, st, bt, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // 1: reset state, startup latency, first capture
    check("rst_req", imem_if.imem_req, 1'b0);
    check("rst_instr", instr, NOP);
    rst = 1'b0;
    step(1, 32'h3, 0, 0, '0);
    check("t1_req_rise", imem_if.imem_req, 1'b1);
    check("t1_addr0", imem_if.imem_addr, 64'h0);
    step(1, 32'h3, 0, 0, '0);
    check("t1_valid", instr_valid, 1'b1);
    check("t1_opcode", opcode, 7'h03);
    step(1, 32'h3, 0, 0, '0);
    check("t1_addr4", imem_if.imem_addr, 64'h4);

    // 2: five wait states at address 8
    step(1, 32'h0000_0033, 0, 0, '0);
    step(1, 32'h0000_0033, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(0, 32'hDEAD_BEEF, 0, 0, '0);
      check("t2_addr_hold", imem_if.imem_addr, 64'h8);
      check("t2_no_valid", instr_valid, 1'b0);
    end
    step(1, 32'h0000_0023, 0, 0, '0);
    check("t2_capture", instr, 32'h0000_0023);

    // 3: stall masks branch, then redirect to 0x40
    step(1, 32'h0, 0, 0, '0);
    step(1, 32'h0000_0013, 0, 0, '0);
    step(1, 32'h0, 0, 0, '0);
    step(1, 32'h0000_0063, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h0, 1, 1, 64'h80);
      check("t3_stall_pc", pc, 64'h10);
    end
    step(1, 32'h0, 0, 1, 64'h40);
    check("t3_redirect", imem_if.imem_addr, 64'h40);

    // 4: PC wrap from the top of the address space
    step(1, 32'h0000_0063, 0, 0, '0);
    step(1, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 32'h0000_006F, 0, 0, '0);
    step(1, 32'h0, 0, 0, '0);
    check("t4_wrap", imem_if.imem_addr, 64'h0);

    // 5: misaligned branch target halts with a sticky fault
    step(1, 32'h0000_0063, 0, 0, '0);
    step(1, 32'h0, 0, 1, 64'h42);
    check("t5_fault", fetch_fault, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 32'h3, 0, 0, '0);
    check("t5_halt_req", imem_if.imem_req, 1'b0);
    do_reset();
    check("t5_fault_clr", fetch_fault, 1'b0);

    // 6: memory never answers; then reset during FETCH
    step(0, 32'h0, 0, 0, '0);
    for (int i = 0; i < 100; i++) step(0, 32'h0, 0, 0, '0);
`ifdef FETCH_TIMEOUT_EN
    check("t6_timeout", fetch_fault, 1'b1);
`else
    check("t6_no_timeout", fetch_fault, 1'b0);
`endif
    do_reset();
    step(0, 32'h0, 0, 0, '0);
    step(0, 32'h0, 0, 0, '0);
    check("t6_in_fetch", imem_if.imem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_req", imem_if.imem_req, 1'b0);
    check("t6_rst_pc", pc, RST_PC);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    begin
      int halted_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
        bit          rdy = ($urandom_range(0, 9) < 7);
        bit          st  = ($urandom_range(0, 9) < 3);
        bit          bt  = ($urandom_range(0, 9) < 3);
        logic [63:0] tgt = {$urandom, $urandom} & ~64'h3;
        if ($urandom_range(0, 31) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        step(rdy, $urandom, st, bt, tgt);
        if (m_halted) halted_cycles++;
        if (halted_cycles > 4) begin
          halted_cycles = 0;
          do_reset();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
